// File: rtl/memory_arbiter_pkg.sv
// Shared types and sizes for the two-port block-RAM read arbiter.
// Optional feature: MEMORY_ARBITER_ROUND_ROBIN_EN selects round-robin tie-breaking.
package memory_arbiter_pkg;

    localparam int unsigned LGMEMSZ = 14;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned LEN_W   = 2;
    localparam int unsigned NREQ    = 2;
    localparam int unsigned OWN_W   = 1;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_BURST
    } state_e;

    // One entry per issued beat, consumed the cycle the memory data returns.
    typedef struct packed {
        logic             valid;
        logic [OWN_W-1:0] owner;
        logic             last;
    } rsp_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Requester and memory-side signals of memory_arbiter, bundled as one interface.
// The arbiter uses the slave modport; the environment (requesters plus RAM) uses master.
interface memory_arbiter_if;
    import memory_arbiter_pkg::*;

    logic [NREQ-1:0]         i_req;
    logic [NREQ*LGMEMSZ-1:0] i_addr;
    logic [NREQ*LEN_W-1:0]   i_len;
    logic [NREQ-1:0]         o_gnt;
    logic [NREQ-1:0]         o_rvalid;
    logic [DATA_W-1:0]       o_rdata;
    logic                    o_rlast;
    logic                    o_mem_read;
    logic [LGMEMSZ-1:0]      o_mem_address;
    logic [DATA_W-1:0]       i_mem_data;

    modport slave (
        input  i_req, i_addr, i_len, i_mem_data,
        output o_gnt, o_rvalid, o_rdata, o_rlast, o_mem_read, o_mem_address
    );

    modport master (
        output i_req, i_addr, i_len, i_mem_data,
        input  o_gnt, o_rvalid, o_rdata, o_rlast, o_mem_read, o_mem_address
    );

endinterface

// File: rtl/memory_arbiter_arb_pick.sv
// Combinational one-hot winner selection for two requesters.
// MEMORY_ARBITER_ROUND_ROBIN_EN adds the pointer input; otherwise port 0 always wins ties.
module arb_pick
    import memory_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] req_i,
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    input  logic            ptr_i,
`endif
    output logic [NREQ-1:0] gnt_o
);

    always_comb begin
        gnt_o = '0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        if (req_i == 2'b11) begin
            gnt_o[ptr_i] = 1'b1;
        end else begin
            gnt_o = req_i;
        end
`else
        if (req_i[0]) begin
            gnt_o = 2'b01;
        end else begin
            gnt_o = req_i;
        end
`endif
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one registered block-RAM read port between two burst requesters (1-4 words).
// Define MEMORY_ARBITER_ROUND_ROBIN_EN for round-robin ties; default is fixed priority.
module memory_arbiter
    import memory_arbiter_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_reset,
    memory_arbiter_if.slave bus
);

    state_e             state_q, state_d;
    logic [OWN_W-1:0]   owner_q, owner_d;
    logic [LGMEMSZ-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    rsp_t               rsp_q, rsp_d;

    logic [NREQ-1:0]    req_v;
    logic [NREQ-1:0]    win;
    logic [OWN_W-1:0]   win_idx;
    logic [LGMEMSZ-1:0] win_addr;
    logic [LEN_W-1:0]   win_len;
    logic               mem_read;
    logic [LGMEMSZ-1:0] mem_addr;

    // Grants only happen in IDLE, and never while reset is held.
    assign req_v    = (state_q == ST_IDLE && !i_reset) ? bus.i_req : '0;
    assign win_idx  = win[1];
    assign win_addr = win_idx ? bus.i_addr[2*LGMEMSZ-1:LGMEMSZ] : bus.i_addr[LGMEMSZ-1:0];
    assign win_len  = win_idx ? bus.i_len[2*LEN_W-1:LEN_W] : bus.i_len[LEN_W-1:0];

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    logic ptr_q, ptr_d;

    arb_pick u_pick (
        .req_i (req_v),
        .ptr_i (ptr_q),
        .gnt_o (win)
    );

    // Pointer names the port that wins the next tie: the one not granted last.
    assign ptr_d = (win != '0) ? ~win_idx : ptr_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    arb_pick u_pick (
        .req_i (req_v),
        .gnt_o (win)
    );
`endif

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        rsp_d    = '0;
        mem_read = 1'b0;
        mem_addr = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (win != '0) begin
                    mem_read = 1'b1;
                    mem_addr = win_addr;
                    owner_d  = win_idx;
                    addr_d   = win_addr + LGMEMSZ'(1);
                    rem_d    = win_len;
                    rsp_d    = '{valid: 1'b1, owner: win_idx, last: (win_len == '0)};
                    if (win_len != '0) begin
                        state_d = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                mem_read = 1'b1;
                mem_addr = addr_q;
                addr_d   = addr_q + LGMEMSZ'(1);
                rem_d    = rem_q - LEN_W'(1);
                rsp_d    = '{valid: 1'b1, owner: owner_q, last: (rem_q == LEN_W'(1))};
                if (rem_q == LEN_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            rsp_q   <= rsp_d;
        end
    end

    assign bus.o_gnt         = win;
    assign bus.o_mem_read    = mem_read;
    assign bus.o_mem_address = mem_addr;
    assign bus.o_rvalid      = rsp_q.valid ? (rsp_q.owner[0] ? 2'b10 : 2'b01) : '0;
    assign bus.o_rdata       = rsp_q.valid ? bus.i_mem_data : '0;
    assign bus.o_rlast       = rsp_q.valid & rsp_q.last;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: directed scenarios then randomized requesters.
// Expected beats come from a queue-based model of grants, burst addresses and returns.
`timescale 1ns/1ps
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    memory_arbiter_if bus ();

    memory_arbiter dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          port;
        logic [13:0] addr;
        bit          last;
    } beat_t;

    beat_t issue_q[$];
    beat_t pend;
    bit    pend_v = 0;
    int    busy   = 0;
    int    rr_fav = 0;

    function automatic logic [31:0] ram_f(input logic [13:0] a);
        return {~a[7:0], a, 10'h2A5};
    endfunction

    // Registered RAM: data for an address read at cycle T is presented during T+1.
    always @(posedge clk) begin
        if (bus.o_mem_read) bus.i_mem_data <= ram_f(bus.o_mem_address);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, exp);
        end
    endtask

    // Monitor and reference model, sampled mid-cycle.
    always @(negedge clk) begin
        logic [1:0] req;
        logic [1:0] exp_gnt;
        int         p;
        int         len;
        logic [13:0] a;
        beat_t      b;
        if (rst) begin
            check("reset_gnt", bus.o_gnt, 0);
            check("reset_rvalid", bus.o_rvalid, 0);
            check("reset_rdata", bus.o_rdata, 0);
            check("reset_rlast", bus.o_rlast, 0);
            check("reset_mem_read", bus.o_mem_read, 0);
            check("reset_mem_address", bus.o_mem_address, 0);
            issue_q.delete();
            pend_v = 0;
            busy   = 0;
            rr_fav = 0;
        end else begin
            if (pend_v) begin
                check("rvalid", bus.o_rvalid, (pend.port == 1) ? 2'b10 : 2'b01);
                check("rdata", bus.o_rdata, ram_f(pend.addr));
                check("rlast", bus.o_rlast, pend.last);
            end else begin
                check("rvalid_idle", bus.o_rvalid, 0);
                check("rdata_idle", bus.o_rdata, 0);
                check("rlast_idle", bus.o_rlast, 0);
            end
            pend_v  = 0;
            exp_gnt = 2'b00;
            req     = bus.i_req;
            if (busy > 0) begin
                busy--;
            end else if (req != 2'b00) begin
                if (req == 2'b11) begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
                    p = rr_fav;
`else
                    p = 0;
`endif
                end else begin
                    p = req[1] ? 1 : 0;
                end
                exp_gnt[p] = 1'b1;
                len = int'(bus.i_len[p*2 +: 2]);
                a   = bus.i_addr[p*14 +: 14];
                for (int k = 0; k <= len; k++) issue_q.push_back('{p, 14'(a + k), k == len});
                busy   = len;
                rr_fav = 1 - p;
            end
            check("gnt", bus.o_gnt, exp_gnt);
            if (issue_q.size() > 0) begin
                b = issue_q.pop_front();
                check("mem_read", bus.o_mem_read, 1);
                check("mem_address", bus.o_mem_address, b.addr);
                pend   = b;
                pend_v = 1;
            end else begin
                check("mem_read_idle", bus.o_mem_read, 0);
            end
        end
    end

    task automatic set_req(input int p, input logic [13:0] a, input logic [1:0] l);
        bus.i_req[p]        = 1'b1;
        bus.i_addr[p*14 +: 14] = a;
        bus.i_len[p*2 +: 2]    = l;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the edge following the grant.
    task automatic request(input int p, input logic [13:0] a, input logic [1:0] l);
        int i = 0;
        set_req(p, a, l);
        forever begin
            @(negedge clk);
            if (bus.o_gnt[p]) break;
            i++;
            if (i >= 50) break;
        end
        n_checks++;
        if (!bus.o_gnt[p]) begin
            n_fail++;
            $display("FAIL grant_timeout port %0d: gnt=%b, required bit %0d set", p, bus.o_gnt, p);
        end
        @(posedge clk);
        #1 bus.i_req[p] = 1'b0;
    endtask

    initial begin
        bus.i_req  = '0;
        bus.i_addr = '0;
        bus.i_len  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        request(0, 14'h0010, 2'd0);
        idle(2);
        request(1, 14'h3FFE, 2'd3);
        idle(5);

        // Both ports contend with single-word requests for six cycles.
        set_req(0, 14'h0100, 2'd0);
        set_req(1, 14'h0200, 2'd0);
        idle(6);
        bus.i_req = '0;
        idle(2);

        // Port 1 arrives mid-burst and must wait without a bubble.
        set_req(0, 14'h0300, 2'd3);
        @(posedge clk);
        #1 bus.i_req[0] = 1'b0;
        request(1, 14'h0400, 2'd0);
        idle(3);

        // Port 1 withdraws during a burst.
        set_req(0, 14'h0500, 2'd3);
        @(posedge clk);
        #1 bus.i_req[0] = 1'b0;
        set_req(1, 14'h0580, 2'd1);
        @(posedge clk);
        #1 bus.i_req[1] = 1'b0;
        idle(6);

        // Reset lands on the second cycle of a burst.
        set_req(0, 14'h0600, 2'd3);
        @(posedge clk);
        #1 bus.i_req[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        idle(1);
        request(1, 14'h0700, 2'd1);
        idle(4);

        for (int c = 0; c < 3000; c++) begin
            logic [1:0] g;
            @(negedge clk);
            g = bus.o_gnt;
            @(posedge clk);
            #1;
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                bus.i_req = '0;
                @(posedge clk);
                #1 rst = 1'b0;
                continue;
            end
            for (int p = 0; p < 2; p++) begin
                logic [13:0] ra;
                ra = ($urandom_range(0, 3) == 0) ? 14'(14'h3FFC + $urandom_range(0, 3))
                                                  : 14'($urandom);
                if (bus.i_req[p] && g[p]) begin
                    if ($urandom_range(0, 1) == 1) set_req(p, ra, 2'($urandom));
                    else bus.i_req[p] = 1'b0;
                end else if (bus.i_req[p]) begin
                    if ($urandom_range(0, 15) == 0) bus.i_req[p] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    set_req(p, ra, 2'($urandom));
                end
            end
        end

        bus.i_req = '0;
        idle(8);
        check("drain_issue_q", 64'(issue_q.size()), 0);
        check("drain_pending", 64'(pend_v), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
